stream_rr_arbiter: RTL and testbench

//  Round-robin arbiter that merges NUM_PORTS FWFT streams (empty_n/read/dout) into one

---
 rtl/stream_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_stream_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Burst-locked round-robin merge of FWFT streams into one tagged FIFO write stream.
// Optional per-port word counters: define STREAM_RR_ARBITER_STATS_EN.
module stream_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8,
    localparam int TAG_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              in_empty_n,
    output logic [NUM_PORTS-1:0]              in_read,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   in_dout,
    input  logic                              out_full_n,
    output logic                              out_write,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0]   out_din
`ifdef STREAM_RR_ARBITER_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]           stat_count
`endif
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);
    localparam logic [TAG_WIDTH-1:0] LAST_RST = TAG_WIDTH'(NUM_PORTS - 1);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                          state_q, state_d;
    logic [TAG_WIDTH-1:0]            grant_q, grant_d;
    logic [TAG_WIDTH-1:0]            last_q, last_d;
    logic [BW-1:0]                   burst_q, burst_d;
    logic                            write_q, write_d;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] din_q, din_d;
    logic [TAG_WIDTH-1:0]            pick;
    logic                            xfer;

    assign out_write = write_q;
    assign out_din   = din_q;

    // First requester after the last served port, wrapping around.
    always_comb begin
        logic                 found;
        logic [TAG_WIDTH-1:0] cand;
        pick  = last_q;
        found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = TAG_WIDTH'((int'(last_q) + i) % NUM_PORTS);
            if (!found && in_empty_n[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        write_d = 1'b0;
        din_d   = din_q;
        in_read = '0;
        xfer    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|in_empty_n) begin
                    grant_d = pick;
                    burst_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                xfer             = in_empty_n[grant_q] & out_full_n;
                in_read[grant_q] = xfer;
                if (xfer) begin
                    write_d = 1'b1;
                    din_d   = {grant_q, in_dout[grant_q*DATA_WIDTH +: DATA_WIDTH]};
                    burst_d = burst_q + BURST_ONE;
                end
                if ((xfer && burst_q == BURST_LAST) || !in_empty_n[grant_q]) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    burst_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            burst_q <= '0;
            write_q <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            write_q <= write_d;
            din_q   <= din_d;
        end
    end

`ifdef STREAM_RR_ARBITER_STATS_EN
    logic [31:0] stat_q [NUM_PORTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) stat_q[p] <= '0;
        end else if (xfer) begin
            stat_q[grant_q] <= stat_q[grant_q] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
        assign stat_count[g*32 +: 32] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: directed source traffic,
// expected tagged words queued up front, negedge monitor pops and compares.
module tb_stream_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NP-1:0]   in_empty_n;
    logic [NP-1:0]   in_read;
    logic [NP*DW-1:0] in_dout;
    logic            out_full_n = 1'b1;
    logic            out_write;
    logic [DW+1:0]   out_din;
`ifdef STREAM_RR_ARBITER_STATS_EN
    logic [NP*32-1:0] stat_count;
`endif

    stream_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_empty_n (in_empty_n),
        .in_read    (in_read),
        .in_dout    (in_dout),
        .out_full_n (out_full_n),
        .out_write  (out_write),
        .out_din    (out_din)
`ifdef STREAM_RR_ARBITER_STATS_EN
        ,
        .stat_count (stat_count)
`endif
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int avail [NP];
    int nxt   [NP];
    int pops  [NP];
    logic [DW+1:0] exp_q [$];
    bit trace [$];
    bit trace_en = 1'b0;

    function automatic logic [DW-1:0] word(int p, int k);
        return 32'hA000_0000 | DW'(p << 16) | DW'(k);
    endfunction

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            in_empty_n[p]       = avail[p] > 0;
            in_dout[p*DW +: DW] = word(p, nxt[p]);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_push(int p, int k0, int n);
        for (int k = k0; k < k0 + n; k++) exp_q.push_back({2'(p), word(p, k)});
    endtask

    // FWFT sources: a pop seen before the edge takes effect just after it.
    initial begin
        logic [NP-1:0] rd;
        for (int p = 0; p < NP; p++) begin
            avail[p] = 0;
            nxt[p]   = 0;
            pops[p]  = 0;
        end
        forever begin
            @(negedge clk);
            rd = in_read;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (rd[p]) begin
                    if (avail[p] > 0) avail[p]--;
                    nxt[p]++;
                    pops[p]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (trace_en) trace.push_back(out_write);
            if (!reset) begin
                chk("in_read_onehot0", 64'($onehot0(in_read)), 64'd1);
                chk("in_read_no_empty_pop", 64'(in_read & ~in_empty_n), 64'd0);
            end
            if (out_write) begin
                if (exp_q.size() == 0) chk("sb_unexpected_write", 64'(out_din), 64'h0);
                else chk("sb_word", 64'(out_din), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        out_full_n = 1'b1;
        for (int p = 0; p < NP; p++) begin
            avail[p] = 0;
            nxt[p]   = 0;
            pops[p]  = 0;
        end
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_write", 64'(out_write), 64'd0);
        chk("rst_out_din", 64'(out_din), 64'd0);
        chk("rst_in_read", 64'(in_read), 64'd0);
        tick();
        trace.delete();
        trace_en = 1'b1;
    endtask

    task automatic drain(string nm);
        int t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            tick();
            t++;
        end
        chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) tick();
        trace_en = 1'b0;
    endtask

    task automatic wait_pops(string nm, int p, int n);
        int t = 0;
        while (pops[p] < n && t < 100) begin
            tick();
            t++;
        end
        chk(nm, 64'(pops[p]), 64'(n));
    endtask

    // Run lengths of out_write=1 and the idle gaps between them.
    task automatic check_runs(string nm, string want);
        string rs = "";
        string gs = "";
        int run = 0;
        int gap = 0;
        bit seen = 1'b0;
        foreach (trace[i]) begin
            if (trace[i]) begin
                if (run == 0 && seen) gs = {gs, $sformatf("%0d,", gap)};
                run++;
            end else begin
                if (run > 0) begin
                    rs = {rs, $sformatf("%0d,", run)};
                    run = 0;
                    seen = 1'b1;
                    gap = 0;
                end
                gap++;
            end
        end
        if (run > 0) rs = {rs, $sformatf("%0d,", run)};
        nchk++;
        if ({rs, "|", gs} != want) begin
            nerr++;
            $display("FAIL %s: got %s want %s", nm, {rs, "|", gs}, want);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: idle inputs
        do_reset();
        repeat (10) begin
            @(negedge clk);
            chk("idle_out_write", 64'(out_write), 64'd0);
            chk("idle_in_read", 64'(in_read), 64'd0);
            tick();
        end

        // 2: single requester, 20 words
        do_reset();
        exp_push(2, 0, 20);
        avail[2] = 20;
        drain("t2");
        check_runs("t2_bursts", "8,8,4,|1,1,");

        // 3: all ports requesting
        do_reset();
        exp_push(0, 0, 8);
        exp_push(1, 0, 8);
        exp_push(2, 0, 8);
        exp_push(3, 0, 8);
        exp_push(0, 8, 8);
        avail[0] = 16;
        avail[1] = 8;
        avail[2] = 8;
        avail[3] = 8;
        drain("t3");
        check_runs("t3_bursts", "8,8,8,8,8,|1,1,1,1,");

        // 4: backpressure mid-burst
        do_reset();
        exp_push(1, 0, 10);
        avail[1] = 10;
        wait_pops("t4_pops3", 1, 3);
        out_full_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall_in_read", 64'(in_read), 64'd0);
            tick();
        end
        out_full_n = 1'b1;
        drain("t4");
        check_runs("t4_bursts", "3,5,2,|5,1,");

        // 5: port 0 runs dry, port 3 waiting
        do_reset();
        exp_push(0, 0, 3);
        exp_push(3, 0, 4);
        avail[0] = 3;
        avail[3] = 4;
        drain("t5");
        check_runs("t5_bursts", "3,4,|2,");

        // 6: reset during a port-1 transfer
        do_reset();
        exp_push(1, 0, 2);
        avail[1] = 10;
        wait_pops("t6_pops2", 1, 2);
        chk("t6_xfer_active", 64'(in_read), 64'd2);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_dropped_write", 64'(out_write), 64'd0);
        chk("t6_idle_in_read", 64'(in_read), 64'd0);
`ifdef STREAM_RR_ARBITER_STATS_EN
        chk("t6_stats_zero", 64'(|stat_count), 64'd0);
`endif
        chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);
        tick();
        exp_push(0, 0, 2);
        exp_push(1, 3, 7);
        avail[0] = 2;
        reset = 1'b0;
        drain("t6");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
